// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and preload constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Byte offsets from BASE_ADDR of the words restored on every reset
    localparam logic [31:0] PRELOAD_ADDR0 = 32'd1000;
    localparam logic [31:0] PRELOAD_ADDR1 = 32'd1004;
    localparam logic [31:0] PRELOAD_DATA0 = 32'h21212121;
    localparam logic [31:0] PRELOAD_DATA1 = 32'h23232323;

    // Reset contents of a given word index: test operands at the preload slots, zero elsewhere
    function automatic logic [31:0] preload_word(input int word);
        if (word == int'(PRELOAD_ADDR0 >> 2)) begin
            return PRELOAD_DATA0;
        end
        if (word == int'(PRELOAD_ADDR1 >> 2)) begin
            return PRELOAD_DATA1;
        end
        return 32'h0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with reset clear and test-operand preload
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Reset rewrites every word (clear plus preload); otherwise a single-word write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= preload_word(i);
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Asynchronous read; the responder registers it at the access edge
    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency valid/ready load/store responder over dmem_array
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h00000000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          access;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [31:0]   word_off;
    logic [IW-1:0] acc_idx;
    logic          acc_err;
    logic [31:0]   arr_rdata;

    // With zero latency the access happens on the accept edge, so it must see the live request
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign word_off = (acc_addr - BASE_ADDR) >> 2;
    assign acc_idx  = word_off[IW-1:0];
    assign acc_err  = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                      (word_off >= 32'(DEPTH));

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (access && acc_we && !acc_err),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    // Next-state and access-strobe decode
    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request on accept and count down the wait cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (state_q == IDLE && req_valid) begin
            cnt_q   <= 4'(LATENCY);
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Response registers change only at the access edge, so they stay stable under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (access) begin
            err_q   <= acc_err;
            rdata_q <= (acc_we || acc_err) ? 32'h0 : arr_rdata;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h00000000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction-level model of u_dut: memory contents plus one outstanding response
    bit          known = 0;
    bit          busy  = 0;
    int          due   = 0;
    logic [31:0] exp_rdata = 0;
    logic        exp_err   = 0;
    logic [31:0] mem_m [DEPTH];

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (((a - BASE) >> 2) >= 32'(DEPTH));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            known = 1;
            busy  = 0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
            mem_m[1000 / 4] = 32'h21212121;
            mem_m[1004 / 4] = 32'h23232323;
        end else if (known) begin
            if (!busy && req_valid) begin
                busy    = 1;
                due     = cyc + LAT + 1;
                exp_err = addr_bad(req_addr);
                if (req_we) begin
                    exp_rdata = 32'h0;
                    if (!exp_err) mem_m[(req_addr - BASE) >> 2] = req_wdata;
                end else begin
                    exp_rdata = exp_err ? 32'h0 : mem_m[(req_addr - BASE) >> 2];
                end
            end else if (busy && cyc >= due && rsp_ready) begin
                busy = 0;
            end
        end
        cyc++;
    end

    // Cycle-by-cycle comparison of u_dut against the model
    always @(negedge clk) begin
        if (known) begin
            if (!busy) begin
                check("idle_req_ready", req_ready, 1);
                check("idle_rsp_valid", rsp_valid, 0);
            end else if (cyc < due) begin
                check("wait_req_ready", req_ready, 0);
                check("wait_rsp_valid", rsp_valid, 0);
            end else begin
                check("resp_rsp_valid", rsp_valid, 1);
                check("resp_req_ready", req_ready, 0);
                check("resp_rdata", rsp_rdata, exp_rdata);
                check("resp_err", rsp_err, exp_err);
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int acc);
        int n;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        acc = -1;
        while (n < 50) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        if (n >= 50) check("req_accept_timeout", 0, 1);
        acc = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rc, output logic [31:0] data, output logic err);
        int n;
        n = 0;
        rc = -1;
        data = 32'h0;
        err = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
        end
        if (n >= 50) check("rsp_timeout", 0, 1);
        rc   = cyc;
        data = rsp_rdata;
        err  = rsp_err;
    endtask

    int          acc, rc, prev_acc;
    logic [31:0] d;
    logic        e;
    logic [31:0] b2b_addr [4] = '{32'd1000, 32'd16, 32'd1004, 32'd0};
    logic [31:0] b2b_data [4] = '{32'h21212121, 32'hA0A0A0A0, 32'h23232323, 32'h0};

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0;
        z_rsp_ready = 1'b1;

        // Reset and preload
        repeat (2) begin
            @(negedge clk);
            check("rst_req_ready", req_ready, 1);
            check("rst_rsp_valid", rsp_valid, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        do_req(1'b0, 32'd1000, 32'h0, acc);
        wait_rsp(rc, d, e);
        check("preload_latency", rc - acc, 3);
        check("preload0_rdata", d, 32'h21212121);
        check("preload0_err", e, 0);

        // Store then load
        do_req(1'b1, 32'd2000, 32'hCAFEF00D, acc);
        wait_rsp(rc, d, e);
        check("store_rdata", d, 32'h0);
        do_req(1'b0, 32'd2000, 32'h0, acc);
        wait_rsp(rc, d, e);
        check("load_back", d, 32'hCAFEF00D);

        // Backpressure on a load of 1004
        do_req(1'b0, 32'd1004, 32'h0, acc);
        rsp_ready = 1'b0;
        wait_rsp(rc, d, e);
        check("bp_rdata", d, 32'h23232323);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_rdata", rsp_rdata, 32'h23232323);
            check("bp_hold_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", req_ready, 1);

        // Error cases
        do_req(1'b0, 32'd1002, 32'h0, acc);
        wait_rsp(rc, d, e);
        check("misalign_err", e, 1);
        check("misalign_rdata", d, 32'h0);
        do_req(1'b1, BASE + 4 * (DEPTH - 1), 32'h5A5A5A5A, acc);
        wait_rsp(rc, d, e);
        do_req(1'b1, BASE + 4 * DEPTH, 32'hDEADBEEF, acc);
        wait_rsp(rc, d, e);
        check("oor_store_err", e, 1);
        check("oor_store_rdata", d, 32'h0);
        do_req(1'b0, BASE + 4 * (DEPTH - 1), 32'h0, acc);
        wait_rsp(rc, d, e);
        check("last_word_kept", d, 32'h5A5A5A5A);
        check("last_word_err", e, 0);

        // Reset during WAIT drops the store
        do_req(1'b1, 32'd3000, 32'h11111111, acc);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        do_req(1'b0, 32'd3000, 32'h0, acc);
        wait_rsp(rc, d, e);
        check("midrst_lost_store", d, 32'h0);

        // Back-to-back loads with rsp_ready tied high
        do_req(1'b1, 32'd16, 32'hA0A0A0A0, acc);
        wait_rsp(rc, d, e);
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, b2b_addr[i], 32'h0, acc);
            if (i > 0) check("b2b_spacing", acc - prev_acc, LAT + 2);
            prev_acc = acc;
            wait_rsp(rc, d, e);
            check("b2b_rdata", d, b2b_data[i]);
        end

        // Zero-latency instance: response one cycle after each accept
        @(posedge clk);
        #1;
        z_req_we = 1'b1; z_req_addr = 32'd2000; z_req_wdata = 32'hCAFEF00D; z_req_valid = 1'b1;
        @(negedge clk);
        check("lat0_store_ready", z_req_ready, 1);
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        check("lat0_store_valid", z_rsp_valid, 1);
        check("lat0_store_rdata", z_rsp_rdata, 32'h0);
        check("lat0_store_err", z_rsp_err, 0);
        @(posedge clk);
        #1;
        z_req_we = 1'b0; z_req_valid = 1'b1;
        @(negedge clk);
        check("lat0_load_ready", z_req_ready, 1);
        check("lat0_idle_valid", z_rsp_valid, 0);
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        check("lat0_load_valid", z_rsp_valid, 1);
        check("lat0_load_rdata", z_rsp_rdata, 32'hCAFEF00D);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the uniciclo CPU family. It is the target side of a valid/ready load/store request bus, with a configurable fixed access latency. It holds a word-addressed RAM preloaded with the standard test operands. It replaces the zero-latency data memory when the datapath is moved to a stalling/multi-cycle core, and it serves as the reference target for bus-master verification.

## Interface
- DEPTH, 1024: number of 32-bit words in the array.
- BASE_ADDR, 32'h00000000: byte address mapped to word 0.
- LATENCY, 2: wait cycles between accept and access, range 0..15.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  master presents a request.
- req_ready  out  1  responder can accept; reset value 1.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response available; reset value 0.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors; reset value 0.
- rsp_err  out  1  misaligned or out-of-range access; reset value 0.

## Operation
- The FSM has three states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/addr/wdata and load cnt <= LATENCY.
  - If LATENCY == 0, perform the access at this edge and go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - req_ready = 0 and rsp_valid = 0.
  - cnt decrements each edge.
  - At the edge where cnt == 1, perform the access and go to RESP.
- RESP:
  - rsp_valid = 1, and rsp_rdata/rsp_err are held stable.
  - On rsp_ready, go to IDLE.
  - rsp_valid stays high until that handshake, with no timeout.
- Access decode:
  - idx = (addr − BASE_ADDR) >> 2.
  - err = (addr[1:0] != 0) | (addr < BASE_ADDR) | (idx >= DEPTH).
- Store with err = 0: mem[idx] <= wdata at the access edge, and rsp_rdata = 0.
- Load with err = 0: rsp_rdata <= mem[idx] as sampled at the access edge.
- err = 1: the array is untouched, rsp_rdata = 0, rsp_err = 1.
- Reset:
  - All words are cleared.
  - Preload mem at byte BASE_ADDR+1000 = 32'h21212121 and at BASE_ADDR+1004 = 32'h23232323.
  - Reset forces IDLE and clears rsp_valid, rsp_err and rsp_rdata.
- rst has priority over every other event. An in-flight transaction is dropped, and a store not yet committed is lost.
- req_* signals are ignored outside IDLE. The master holds them only until the handshake.

## Timing
- Request handshake in cycle 0 gives rsp_valid high from cycle LATENCY+1.
- A store becomes visible to a load accepted no earlier than cycle LATENCY+1.
- After a response handshake in cycle k, the FSM is in IDLE at k+1 and a new request can be accepted in k+1.
- Best-case throughput is one transaction per LATENCY+2 cycles.
- There is no combinational path from req_valid to req_ready, or from rsp_ready to rsp_valid. Outputs are pure functions of state and registers.
- rsp_rdata and rsp_err change only on the access edge or on reset.
- cnt is 4 bits and never wraps, because it is loaded only from LATENCY ≤ 15.

## Structure
- Package dmem_pkg holds:
  - The state enum {IDLE, WAIT, RESP}.
  - PRELOAD_ADDR0 = 1000, PRELOAD_ADDR1 = 1004.
  - PRELOAD_DATA0 = 32'h21212121, PRELOAD_DATA1 = 32'h23232323.
- Sub-module dmem_array holds the word array:
  - Inputs: clk, rst, we, idx, wdata.
  - Output: rdata.
  - It applies the reset clear and preload.
- dmem_responder owns the FSM, the counter, the decode/error logic and the output registers.

## Test plan
- **Reset preload:** rst for 2 cycles, then load at addr 1000 with LATENCY=2.
  - Required: req_ready=1 and rsp_valid=0 during reset.
  - Required: rsp_valid rises exactly 3 cycles after accept, with rsp_rdata=32'h21212121 and rsp_err=0.
- **Store then load:** store 32'hCAFEF00D to 2000, then load 2000.
  - Required: the load returns 32'hCAFEF00D and the store response has rdata 0.
  - Required: with LATENCY=0, rsp_valid appears 1 cycle after each accept.
- **Backpressure:** hold rsp_ready=0 for 5 cycles during a load of 1004.
  - Required: rsp_valid stays 1, rdata=32'h23232323 is stable, and req_ready=0 throughout.
  - Required: after release, req_ready=1 in the next cycle.
- **Errors:**
  - Load at 1002 gives err=1 and rdata=0.
  - Store at BASE_ADDR+4*DEPTH gives err=1, and a follow-up load of word DEPTH−1 is unchanged.
- **Reset mid-operation:** accept a store of 32'h11111111 to 3000, then assert rst during WAIT.
  - Required: the FSM is in IDLE, rsp_valid=0, and a later load of 3000 returns 0.
- **Back-to-back:** 4 loads issued with rsp_ready tied 1.
  - Required: accepts are exactly LATENCY+2 cycles apart and the data matches in order.
